vga_text_console: RTL and testbench

Parametrised text-mode VGA engine, successor to the fixed 70x30 text path. Generates VGA timing and walks the character buffer, applying a hardware scroll offset with row wrap-around. Fetches glyph rows from an external font ROM through a fixed 3-cycle pipeline and drives 12-bit RGB with a blinking inverse-video cursor. Sits between the character buffer RAM / font ROM and the board VGA pins, on the 25 MHz pixel clock.

---
 rtl/vga_text_console_if.sv | 27 ++
 rtl/vga_text_console.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_text_console.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vga_text_console_if.sv
// Memory-side bus of the text console: character buffer read port and font ROM read port.
// Both memories return data one clock after the address is presented.
interface vga_text_console_if #(
   parameter int COL_W  = 7,
   parameter int ROW_W  = 5,
   parameter int FH_W   = 4,
   parameter int FONT_W = 9
);
   logic [ROW_W+COL_W-1:0] char_rd_addr;
   logic [7:0]             char_out;
   logic [8+FH_W-1:0]      font_rd_addr;
   logic [FONT_W-1:0]      font_row;

   modport master (
      output char_rd_addr,
      output font_rd_addr,
      input  char_out,
      input  font_row
   );

   modport slave (
      input  char_rd_addr,
      input  font_rd_addr,
      output char_out,
      output font_row
   );
endinterface

// File: rtl/vga_text_console.sv
// Text-mode VGA engine: raster timing, scrolled character-buffer walk, 3-stage glyph
// fetch pipeline and blinking inverse-video cursor.
module vga_text_console #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int FONT_W       = 9,
   parameter int FONT_H       = 16,
   parameter int FH_W         = 4,
   parameter int COLS         = 70,
   parameter int ROWS         = 30,
   parameter int COL_W        = 7,
   parameter int ROW_W        = 5,
   parameter int BLINK_FRAMES = 30,
   parameter logic [11:0] FG  = 12'hFFF,
   parameter logic [11:0] BG  = 12'h000
) (
   input  logic                 clk_25m,
   input  logic                 rst_n,
   input  logic [ROW_W-1:0]     scroll_row,
   input  logic                 cursor_en,
   input  logic [COL_W-1:0]     cursor_col,
   input  logic [ROW_W-1:0]     cursor_row,
   vga_text_console_if.master   mem,
   output logic [3:0]           VGA_R,
   output logic [3:0]           VGA_G,
   output logic [3:0]           VGA_B,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);
   localparam int HF_W    = $clog2(FONT_W);
   localparam int BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int RW1     = ROW_W + 1;

   localparam logic [HC_W-1:0]  H_LAST  = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0]  H_ACT   = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0]  HS_BEG  = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0]  HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0]  V_LAST  = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0]  V_ACT   = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0]  VS_BEG  = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0]  VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [HF_W-1:0]  HF_LAST = HF_W'(FONT_W - 1);
   localparam logic [FH_W-1:0]  VF_LAST = FH_W'(FONT_H - 1);
   localparam logic [COL_W-1:0] COLS_C  = COL_W'(COLS);
   localparam logic [ROW_W-1:0] ROWS_C  = ROW_W'(ROWS);
   localparam logic [RW1-1:0]   ROWS_S  = RW1'(ROWS);
   localparam logic [BF_W-1:0]  BF_LAST = BF_W'(BLINK_FRAMES - 1);

   logic              run_q;
   logic [HC_W-1:0]   h_cnt;
   logic [VC_W-1:0]   v_cnt;
   logic [HF_W-1:0]   h_font;
   logic [COL_W-1:0]  h_char;
   logic [FH_W-1:0]   v_font;
   logic [ROW_W-1:0]  v_char;

   logic [ROW_W-1:0]  scroll_q;
   logic [COL_W-1:0]  ccol_q;
   logic [ROW_W-1:0]  crow_q;
   logic              cen_q;
   logic [BF_W-1:0]   blink_cnt;
   logic              blink_phase;

   // run_q holds the raster at 0,0 for one cycle after reset so the first
   // frame_start lands in the first cycle after release.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
         h_font <= '0;
         h_char <= '0;
         v_font <= '0;
         v_char <= '0;
      end else begin
         run_q <= 1'b1;
         if (run_q) begin
            if (h_cnt == H_LAST) begin
               h_cnt  <= '0;
               h_font <= '0;
               h_char <= '0;
               if (v_cnt == V_LAST) begin
                  v_cnt  <= '0;
                  v_font <= '0;
                  v_char <= '0;
               end else begin
                  v_cnt <= v_cnt + 1'b1;
                  if (v_font == VF_LAST) begin
                     v_font <= '0;
                     v_char <= v_char + 1'b1;
                  end else begin
                     v_font <= v_font + 1'b1;
                  end
               end
            end else begin
               h_cnt <= h_cnt + 1'b1;
               if (h_font == HF_LAST) begin
                  h_font <= '0;
                  h_char <= h_char + 1'b1;
               end else begin
                  h_font <= h_font + 1'b1;
               end
            end
         end
      end
   end

   assign frame_start = run_q && (h_cnt == '0) && (v_cnt == '0);

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         scroll_q    <= '0;
         ccol_q      <= '0;
         crow_q      <= '0;
         cen_q       <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (frame_start) begin
         scroll_q <= (scroll_row >= ROWS_C) ? '0 : scroll_row;
         ccol_q   <= cursor_col;
         crow_q   <= cursor_row;
         cen_q    <= cursor_en;
         if (blink_cnt == BF_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Stage 0: buffer address with scroll wrap, plus per-pixel attributes.
   logic [RW1-1:0]   row_sum;
   logic [ROW_W-1:0] phys_row;
   logic             active0, hs0, vs0, text0, cur0;

   assign row_sum  = {1'b0, v_char} + {1'b0, scroll_q};
   assign phys_row = (row_sum >= ROWS_S) ? ROW_W'(row_sum - ROWS_S) : row_sum[ROW_W-1:0];
   assign mem.char_rd_addr = {phys_row, h_char};

   assign active0 = run_q && (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs0     = !(run_q && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vs0     = !(run_q && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
   assign text0   = (h_char < COLS_C) && (v_char < ROWS_C);
   assign cur0    = cen_q && blink_phase && (h_char == ccol_q) && (v_char == crow_q);

   logic [HF_W-1:0] hf_d1, hf_d2;
   logic [FH_W-1:0] vf_d1;
   logic            act_d1, act_d2, hs_d1, hs_d2, vs_d1, vs_d2;
   logic            txt_d1, txt_d2, cur_d1, cur_d2;

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         hf_d1  <= '0;
         hf_d2  <= '0;
         vf_d1  <= '0;
         act_d1 <= 1'b0;
         act_d2 <= 1'b0;
         hs_d1  <= 1'b1;
         hs_d2  <= 1'b1;
         vs_d1  <= 1'b1;
         vs_d2  <= 1'b1;
         txt_d1 <= 1'b0;
         txt_d2 <= 1'b0;
         cur_d1 <= 1'b0;
         cur_d2 <= 1'b0;
      end else begin
         hf_d1  <= h_font;
         hf_d2  <= hf_d1;
         vf_d1  <= v_font;
         act_d1 <= active0;
         act_d2 <= act_d1;
         hs_d1  <= hs0;
         hs_d2  <= hs_d1;
         vs_d1  <= vs0;
         vs_d2  <= vs_d1;
         txt_d1 <= text0;
         txt_d2 <= txt_d1;
         cur_d1 <= cur0;
         cur_d2 <= cur_d1;
      end
   end

   // Stage 1: char code is back, request its glyph line.
   assign mem.font_rd_addr = {mem.char_out, vf_d1};

   // Stage 2: glyph row is back, pick the pixel and apply cursor inversion.
   logic        pix_bit;
   logic [11:0] rgb_next, rgb_q;

   assign pix_bit = mem.font_row[HF_LAST - hf_d2];

   always_comb begin
      rgb_next = 12'h000;
      if (act_d2) begin
         if (!txt_d2) rgb_next = BG;
         else         rgb_next = (pix_bit ^ cur_d2) ? FG : BG;
      end
   end

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q  <= 12'h000;
         VGA_HS <= 1'b1;
         VGA_VS <= 1'b1;
      end else begin
         rgb_q  <= rgb_next;
         VGA_HS <= hs_d2;
         VGA_VS <= vs_d2;
      end
   end

   assign VGA_R = rgb_q[11:8];
   assign VGA_G = rgb_q[7:4];
   assign VGA_B = rgb_q[3:0];
endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console on a shrunken raster, compared cycle by
// cycle against an arithmetic screen model (position -> cell -> glyph bit -> colour).
module tb_vga_text_console;
   localparam int HA = 40, HFP = 4, HSY = 6, HBP = 4;
   localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
   localparam int FW = 4, FH = 4, FHW = 2;
   localparam int NC = 8, NR = 4, CW = 4, RW = 3, BF = 2;
   localparam logic [11:0] FGC = 12'hEA5;
   localparam logic [11:0] BGC = 12'h148;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   logic          clk_25m = 1'b0;
   logic          rst_n;
   logic [RW-1:0] scroll_row;
   logic          cursor_en;
   logic [CW-1:0] cursor_col;
   logic [RW-1:0] cursor_row;
   logic [3:0]    vga_r, vga_g, vga_b;
   logic          vga_hs, vga_vs, frame_start;

   always #20 clk_25m = ~clk_25m;

   vga_text_console_if #(.COL_W(CW), .ROW_W(RW), .FH_W(FHW), .FONT_W(FW)) mem_if ();

   vga_text_console #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FONT_W(FW), .FONT_H(FH), .FH_W(FHW),
      .COLS(NC), .ROWS(NR), .COL_W(CW), .ROW_W(RW),
      .BLINK_FRAMES(BF), .FG(FGC), .BG(BGC)
   ) dut (
      .clk_25m     (clk_25m),
      .rst_n       (rst_n),
      .scroll_row  (scroll_row),
      .cursor_en   (cursor_en),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .mem         (mem_if),
      .VGA_R       (vga_r),
      .VGA_G       (vga_g),
      .VGA_B       (vga_b),
      .VGA_HS      (vga_hs),
      .VGA_VS      (vga_vs),
      .frame_start (frame_start)
   );

   logic [7:0]    cmem [0:(1<<(RW+CW))-1];
   logic [FW-1:0] fmem [0:(1<<(8+FHW))-1];

   // Character buffer and font ROM: one-cycle synchronous reads.
   always @(posedge clk_25m) begin
      mem_if.char_out <= cmem[mem_if.char_rd_addr];
      mem_if.font_row <= fmem[mem_if.font_rd_addr];
   end

   int   n_tests = 0;
   int   n_fail  = 0;
   int   k       = 0;
   int   m_scroll = 0, m_ccol = 0, m_crow = 0, m_fcnt = 0;
   bit   m_en = 0, m_phase = 1, latch_pend = 0;
   bit   prev_valid = 0;
   int   prev_addr = 0, prev_line = 0;
   exp_t exq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at sample %0d: got %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   function automatic exp_t model_px(input int h, input int v);
      exp_t e;
      int   col, row, line, fr, phys, c, bits;
      bit   on;
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
      e.rgb = 12'h000;
      if (h < HA && v < VA) begin
         col = h / FW; fr = h % FW; row = v / FH; line = v % FH;
         if (col >= NC || row >= NR) begin
            e.rgb = BGC;
         end else begin
            phys = (row + m_scroll) % NR;
            c    = int'(cmem[phys * (1 << CW) + col]);
            bits = int'(fmem[c * (1 << FHW) + line]);
            on   = bits[FW - 1 - fr];
            if (m_en && col == m_ccol && row == m_crow && m_phase) on = !on;
            e.rgb = on ? FGC : BGC;
         end
      end
      return e;
   endfunction

   task automatic step();
      exp_t ex;
      int   p, fpos, h, v, addr;
      @(negedge clk_25m);
      k++;
      if (latch_pend) begin
         m_scroll = (int'(scroll_row) >= NR) ? 0 : int'(scroll_row);
         m_ccol   = int'(cursor_col);
         m_crow   = int'(cursor_row);
         m_en     = cursor_en;
         m_fcnt++;
         if (m_fcnt == BF) begin
            m_fcnt  = 0;
            m_phase = !m_phase;
         end
         latch_pend = 0;
      end
      p    = k - 1;
      fpos = p % FRAME;
      h    = fpos % HT;
      v    = fpos / HT;
      chk("frame_start", frame_start, fpos == 0);
      exq.push_back(model_px(h, v));
      ex = exq.pop_front();
      chk("rgb", {vga_r, vga_g, vga_b}, ex.rgb);
      chk("hs", vga_hs, ex.hs);
      chk("vs", vga_vs, ex.vs);
      if (prev_valid)
         chk("font_rd_addr", mem_if.font_rd_addr, int'(cmem[prev_addr]) * (1 << FHW) + prev_line);
      prev_valid = 0;
      if (v < VA && h / FW < NC && v / FH < NR) begin
         addr = ((v / FH + m_scroll) % NR) * (1 << CW) + h / FW;
         chk("char_rd_addr", mem_if.char_rd_addr, addr);
         prev_valid = 1;
         prev_addr  = addr;
         prev_line  = v % FH;
      end
      if (fpos == 0) latch_pend = 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 1'b0;
      scroll_row = '0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
      for (int a = 0; a < (1 << (RW + CW)); a++) cmem[a] = 8'($urandom);
      for (int a = 0; a < (1 << (8 + FHW)); a++) fmem[a] = FW'($urandom);
      cmem[0] = 8'h41;
      cmem[(1 << CW) + 2] = 8'h41;
      for (int l = 0; l < FH; l++) fmem[8'h41 * (1 << FHW) + l] = 4'b1001;
      for (int i = 0; i < 3; i++) exq.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1});

      for (int i = 0; i < 10; i++) begin
         @(negedge clk_25m);
         chk("rst_hs", vga_hs, 1'b1);
         chk("rst_vs", vga_vs, 1'b1);
         chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
         chk("rst_frame_start", frame_start, 1'b0);
      end
      rst_n = 1'b1;

      run(FRAME);                        // plain frame, scroll 0, no cursor
      scroll_row = RW'(NR - 1);
      run(FRAME);                        // scroll wrap
      scroll_row = 3'd7;
      run(FRAME / 2);
      scroll_row = 3'd2;                 // mid-frame change, next frame only
      run(FRAME + FRAME / 2);
      scroll_row = 3'd0;
      cursor_en = 1'b1; cursor_col = 4'd5; cursor_row = 3'd3;
      run(2 * FRAME + 700);
      cursor_col = 4'd1; cursor_row = 3'd0;
      run(2 * FRAME);
      for (int s = 0; s < 6; s++) begin
         scroll_row = RW'($urandom_range(0, 7));
         cursor_en  = 1'($urandom_range(0, 1));
         cursor_col = CW'($urandom_range(0, NC + 1));
         cursor_row = RW'($urandom_range(0, NR));
         run(int'($urandom_range(300, 1500)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
